// File: rtl/mips_pkg.sv
// Opcode and descriptor-kind table shared by the main decoder and the IMEM loader.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_LW   = 3'd1;
    localparam logic [2:0] KIND_SW   = 3'd2;
    localparam logic [2:0] KIND_BEQ  = 3'd3;
    localparam logic [2:0] KIND_ADDI = 3'd4;
    localparam logic [2:0] KIND_J    = 3'd5;

    // Loader FSM encoding, also visible on the dbg_state port.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    typedef struct packed {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_desc_t;

endpackage

// File: rtl/instr_packer.sv
// Combinational encoder: one instruction descriptor -> 32-bit MIPS word plus a legality flag.
module instr_packer
    import mips_pkg::*;
(
    input  instr_desc_t desc,
    output logic        legal,
    output logic [31:0] word
);

    // Only the fields belonging to the selected format reach the word.
    always_comb begin
        legal = 1'b1;
        word  = 32'd0;
        case (desc.kind)
            KIND_R:    word = {OP_RTYPE, desc.rs, desc.rt, desc.rd, desc.shamt, desc.funct};
            KIND_LW:   word = {OP_LW,    desc.rs, desc.rt, desc.imm};
            KIND_SW:   word = {OP_SW,    desc.rs, desc.rt, desc.imm};
            KIND_BEQ:  word = {OP_BEQ,   desc.rs, desc.rt, desc.imm};
            KIND_ADDI: word = {OP_ADDI,  desc.rs, desc.rt, desc.imm};
            KIND_J:    word = {OP_J,     desc.target};
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Packs instruction descriptors into MIPS words and writes them sequentially into IMEM from BASE_ADDR.
// Handshake: a descriptor transfers on a rising edge where in_valid && in_ready; in_ready never depends on in_valid.
module instr_mem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_kind,
    input  logic [4:0]                   in_rs,
    input  logic [4:0]                   in_rt,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_shamt,
    input  logic [5:0]                   in_funct,
    input  logic [15:0]                  in_imm,
    input  logic [25:0]                  in_target,
    output logic                         imem_we,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic                         full,
    output logic                         err_illegal,
    output logic [1:0]                   dbg_state
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    instr_desc_t desc;
    logic        legal;
    logic [31:0] word;
    logic        accept;

    assign desc = '{kind: in_kind, rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                    funct: in_funct, imm: in_imm, target: in_target};

    instr_packer u_packer (
        .desc  (desc),
        .legal (legal),
        .word  (word)
    );

    assign in_ready = (state_q == ST_LOAD) && !start;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = ST_LOAD;
            ptr_d   = BASE;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = word;
                count_d = count_q + CNT_W'(1);
                // The last slot leaves the pointer in place, so it never runs past the session window.
                if (count_q == LAST_CNT) begin
                    state_d = ST_FULL;
                    full_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(4);
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= BASE;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign word_count  = count_q;
    assign full        = full_q;
    assign err_illegal = err_q;
    assign dbg_state   = state_q;

endmodule
